imem_loader: RTL and testbench

//   Writer side of the instruction memory: accepts a byte stream over a valid/ready

---
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream writer for the instruction memory.
// The stream is CNT_HI, CNT_LO, then N big-endian words sent as HI,LO bytes.
// Each word goes out through one instrmem write port. The processor is held
// in reset until the whole image has been written.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte. A mismatch aborts the load into the error state.
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'hffff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        proc_reset
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  // Where the stream goes once the last count or data byte has been taken.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;      // word count from the header
  logic [7:0]  hi_q, hi_d;        // high byte held until its low byte arrives
  logic [15:0] idx_q, idx_d;      // index of the word being assembled
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;      // running XOR of every accepted byte
`endif

  logic        accept;
  logic [15:0] hdr;

  // in_ready comes from the state alone, so a source may wait for it before raising valid.
  assign in_ready = (state_q == S_CNT_HI)  || (state_q == S_CNT_LO) ||
                    (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                    (state_q == S_CHK);
  assign accept   = in_valid && in_ready;
  assign hdr      = {hi_q, in_data};

  assign busy       = in_ready;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign proc_reset = (state_q != S_DONE);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  // Next-state logic: every stream state advances only on an accepted byte.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d   = accept ? (chk_q ^ in_data) : chk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_CNT_HI;
          idx_d   = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d   = 8'd0;
`endif
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          cnt_d = hdr;
          if (hdr == 16'd0)            state_d = S_FIN;
          else if (hdr > MAX_WORDS)    state_d = S_ERR;
          else                         state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + idx_q;
          wdata_d = {hi_q, in_data};
          idx_d   = idx_q + 16'd1;
          state_d = (idx_q == cnt_q - 16'd1) ? S_FIN : S_DATA_HI;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      hi_q    <= 8'd0;
      idx_q   <= 16'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random images checked against a
// word-list reference model (expected writes, final status).
module tb_imem_loader;
  localparam logic [15:0] BASE = 16'hfffe;
  localparam logic [15:0] MAXW = 16'd6;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done, error, proc_reset;
  logic [15:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .error(error), .proc_reset(proc_reset)
  );

  int checks = 0, failures = 0;
  logic [15:0] wa[$], wd[$];
  logic [15:0] img[$];
  bit   track_busy = 1'b0;
  bit   start_noise = 1'b0;
  int   busy_drops = 0;

  // Write log of the instrmem port, one entry per strobe cycle.
  always @(negedge clk) if (mem_we === 1'b1) begin
    wa.push_back(mem_addr);
    wd.push_back(mem_wdata);
  end

  // busy must stay high from start until the last byte is taken.
  always @(negedge clk) if (track_busy && busy !== 1'b1) busy_drops++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    start    = start_noise ? 1'($urandom_range(1, 0)) : 1'b0;
    while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   32'd0);
    chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
    chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_error"},      32'(error),      32'd0);
    chk({tag, "_proc_reset"}, 32'(proc_reset), 32'd1);
  endtask

  // Send one image with header count n (words from img) and compare the
  // outcome with the model: words land at BASE+i, status from the header
  // limit and the trailing checksum.
  task automatic load(input logic [15:0] n, input int gmin, input int gmax, input bit bad_chk);
    logic [7:0]  bytes[$];
    logic [7:0]  x;
    logic [15:0] ea;
    bit ovf, exp_err;
    int base_i, expn, got_n;
    base_i = wa.size();
    ovf = (n > MAXW);
    bytes.push_back(n[15:8]);
    bytes.push_back(n[7:0]);
    if (!ovf) for (int i = 0; i < int'(n); i++) begin
      bytes.push_back(img[i][15:8]);
      bytes.push_back(img[i][7:0]);
    end
    x = 8'd0;
    foreach (bytes[i]) x ^= bytes[i];
    if (CK && !ovf) bytes.push_back(bad_chk ? (x ^ 8'h5a) : x);
    exp_err = ovf || (CK && bad_chk);
    expn    = ovf ? 0 : int'(n);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_error", 32'(error), 32'd0);
    chk("start_proc_reset", 32'(proc_reset), 32'd1);
    busy_drops = 0;
    track_busy = 1'b1;
    for (int i = 0; i < bytes.size(); i++)
      send(bytes[i], (i == bytes.size() - 1) ? 0 : int'($urandom_range(gmax, gmin)));
    track_busy = 1'b0;
    // One cycle after the final byte.
    chk("fin_done", 32'(done), 32'(!exp_err));
    chk("fin_error", 32'(error), 32'(exp_err));
    chk("fin_proc_reset", 32'(proc_reset), 32'(exp_err));
    chk("fin_busy", 32'(busy), 32'd0);
    chk("fin_in_ready", 32'(in_ready), 32'd0);
    chk("fin_mem_we", 32'(mem_we), 32'(!CK && expn > 0));
    repeat (3) begin @(posedge clk); #1; end
    chk("busy_held", 32'(busy_drops), 32'd0);
    chk("sticky_done", 32'(done), 32'(!exp_err));
    got_n = wa.size() - base_i;
    chk("nwrites", 32'(got_n), 32'(expn));
    for (int i = 0; i < expn && i < got_n; i++) begin
      ea = BASE + 16'(i);
      chk("waddr", 32'(wa[base_i + i]), 32'(ea));
      chk("wdata", 32'(wd[base_i + i]), 32'(img[i]));
    end
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(16'($urandom));
  endtask

  initial begin
    int base_i, n;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) begin @(posedge clk); #1; end
    check_reset_state("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Basic two-word image, back-to-back bytes.
    img = '{16'h1234, 16'habcd};
    load(16'd2, 0, 0, 1'b0);
    // Same image with valid toggling every cycle.
    load(16'd2, 1, 1, 1'b0);
    // Three words cross the 16-bit address wrap.
    img = '{16'h1111, 16'h2222, 16'h3333};
    load(16'd3, 0, 2, 1'b0);
    // Header limit: MAXW accepted, MAXW+1 rejected.
    rand_img(int'(MAXW));
    load(MAXW, 0, 1, 1'b0);
    load(MAXW + 16'd1, 0, 0, 1'b0);
    // Empty image.
    load(16'd0, 0, 0, 1'b0);

    // Reset after three data bytes: one word written, nothing more.
    base_i = wa.size();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    send(8'h00, 0); send(8'h02, 0); send(8'h12, 0); send(8'h34, 0); send(8'hab, 0);
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    check_reset_state("midrst");
    in_valid = 1'b1; in_data = 8'hcd;
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("midrst_nwrites", 32'(wa.size() - base_i), 32'd1);
    chk("midrst_waddr", 32'(wa[base_i]), 32'(BASE));
    chk("midrst_wdata", 32'(wd[base_i]), 32'h1234);
    img = '{16'h1234, 16'habcd};
    load(16'd2, 0, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img = '{16'h1234};
    load(16'd1, 0, 0, 1'b0);
    load(16'd1, 0, 0, 1'b1);
`endif

    // Random images, random stalls, start pulses while busy.
    start_noise = 1'b1;
    repeat (8) begin
      n = int'($urandom_range(int'(MAXW), 0));
      rand_img(n);
      load(16'(n), 0, int'($urandom_range(3, 0)), CK && ($urandom_range(3, 0) == 0));
    end
    start_noise = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
